// File: rtl/signal_extend_mc_if.sv
// rtl/signal_extend_mc_if.sv - per-channel strobe/data bundle for the pulse stretcher
interface signal_extend_mc_if #(
    parameter int CH_NUM = 4,
    parameter int DATA_W = 1
);
    logic [CH_NUM-1:0]        i_vld;
    logic [CH_NUM*DATA_W-1:0] i_data;
    logic [CH_NUM-1:0]        o_vld;
    logic [CH_NUM*DATA_W-1:0] o_data;
    logic [CH_NUM-1:0]        o_done;
    logic [CH_NUM-1:0]        o_drop;

    modport master (
        output i_vld, i_data,
        input  o_vld, o_data, o_done, o_drop
    );

    modport slave (
        input  i_vld, i_data,
        output o_vld, o_data, o_done, o_drop
    );
endinterface

// File: rtl/signal_extend_mc.sv
// rtl/signal_extend_mc.sv - multi-channel pulse stretcher with programmable length and retrigger
// Each channel turns a one-cycle strobe into an L-cycle valid window holding the captured data.
module signal_extend_mc #(
    parameter int   CH_NUM  = 4,
    parameter int   DATA_W  = 1,
    parameter int   EXT_MAX = 16,
    localparam int  CNT_W   = $clog2(EXT_MAX + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clr,
    input  logic               i_retrig,
    input  logic [CNT_W-1:0]   i_ext_len,
    signal_extend_mc_if.slave  ch,
    output logic               o_busy
);
    localparam logic [CNT_W-1:0] EXT_MAX_C = CNT_W'(EXT_MAX);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic [CH_NUM-1:0]             vld_q, vld_d;
    logic [CH_NUM-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_NUM-1:0][CNT_W-1:0]  len_q, len_d;
    logic [CH_NUM*DATA_W-1:0]      data_q, data_d;
    logic [CH_NUM-1:0]             done_q, done_d;
    logic [CH_NUM-1:0]             drop_q, drop_d;
    logic [CH_NUM-1:0]             last;
    logic [CNT_W-1:0]              len_eff;

    always_comb begin
        len_eff = i_ext_len;
        if (i_ext_len == '0)
            len_eff = ONE_C;
        else if (i_ext_len > EXT_MAX_C)
            len_eff = EXT_MAX_C;
    end

    always_comb begin
        for (int c = 0; c < CH_NUM; c++)
            last[c] = vld_q[c] && (cnt_q[c] == len_q[c]);
    end

    always_comb begin
        vld_d  = vld_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        data_d = data_q;
        done_d = '0;
        drop_d = '0;
        if (i_clr) begin
            vld_d  = '0;
            cnt_d  = '0;
            len_d  = '0;
            data_d = '0;
        end else begin
            for (int c = 0; c < CH_NUM; c++) begin
                done_d[c] = last[c];
                if (ch.i_vld[c] && (!vld_q[c] || last[c] || i_retrig)) begin
                    vld_d[c] = 1'b1;
                    cnt_d[c] = ONE_C;
                    len_d[c] = len_eff;
                    data_d[c*DATA_W +: DATA_W] = ch.i_data[c*DATA_W +: DATA_W];
                end else if (vld_q[c]) begin
                    // An active, non-final channel that still sees a strobe here is refusing it.
                    drop_d[c] = ch.i_vld[c];
                    if (last[c]) begin
                        vld_d[c] = 1'b0;
                        data_d[c*DATA_W +: DATA_W] = '0;
                    end else begin
                        cnt_d[c] = cnt_q[c] + ONE_C;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q  <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
            data_q <= '0;
            done_q <= '0;
            drop_q <= '0;
            o_busy <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            data_q <= data_d;
            done_q <= done_d;
            drop_q <= drop_d;
            o_busy <= |vld_d;
        end
    end

    assign ch.o_vld  = vld_q;
    assign ch.o_data = data_q;
    assign ch.o_done = done_q;
    assign ch.o_drop = drop_q;
endmodule

// File: tb/tb_signal_extend_mc.sv
// tb/tb_signal_extend_mc.sv - self-checking bench for signal_extend_mc
module tb_signal_extend_mc;
    localparam int CH = 4;
    localparam int EXT_MAX = 16;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_clr = 1'b0;
    logic       i_retrig = 1'b0;
    logic [4:0] i_ext_len = '0;
    logic       o_busy;

    signal_extend_mc_if #(.CH_NUM(CH), .DATA_W(1)) bus ();

    signal_extend_mc #(.CH_NUM(CH), .DATA_W(1), .EXT_MAX(EXT_MAX)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (i_clr),
        .i_retrig  (i_retrig),
        .i_ext_len (i_ext_len),
        .ch        (bus.slave),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel remembers the absolute cycle of its last active cycle.
    int         cyc = 0;
    int         end_c [CH];
    logic [3:0] dat_m, done_m, drop_m;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) end_c[c] = -1;
        dat_m = '0; done_m = '0; drop_m = '0;
    endtask

    task automatic model_step(input logic clr, input logic rt, input logic [4:0] len,
                              input logic [3:0] v, input logic [3:0] d);
        int  l;
        bit  act, fin, acc;
        l = (len == 0) ? 1 : ((int'(len) > EXT_MAX) ? EXT_MAX : int'(len));
        for (int c = 0; c < CH; c++) begin
            act = (cyc <= end_c[c]);
            fin = act && (cyc == end_c[c]);
            if (clr) begin
                end_c[c] = -1; dat_m[c] = 1'b0; done_m[c] = 1'b0; drop_m[c] = 1'b0;
            end else begin
                acc = v[c] && (!act || fin || rt);
                done_m[c] = fin;
                drop_m[c] = v[c] && !acc;
                if (acc) begin
                    end_c[c] = cyc + l;
                    dat_m[c] = d[c];
                end
            end
        end
        cyc++;
    endtask

    function automatic logic [3:0] model_vld();
        logic [3:0] r;
        for (int c = 0; c < CH; c++) r[c] = (cyc <= end_c[c]);
        return r;
    endfunction

    task automatic cycle(input logic clr, input logic rt, input logic [4:0] len,
                         input logic [3:0] v, input logic [3:0] d);
        logic [3:0] ev;
        i_clr = clr; i_retrig = rt; i_ext_len = len; bus.i_vld = v; bus.i_data = d;
        model_step(clr, rt, len, v, d);
        @(posedge i_clk);
        #1;
        ev = model_vld();
        chk("m_vld",  32'(bus.o_vld),  32'(ev));
        chk("m_data", 32'(bus.o_data), 32'(ev & dat_m));
        chk("m_done", 32'(bus.o_done), 32'(done_m));
        chk("m_drop", 32'(bus.o_drop), 32'(drop_m));
        chk("m_busy", 32'(o_busy),     32'(|ev));
    endtask

    typedef struct {
        logic       clr;
        logic       rt;
        logic [4:0] len;
        logic [3:0] v, d;
        logic [3:0] e_vld, e_data, e_done, e_drop;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic clr, input logic rt, input logic [4:0] len,
                       input logic [3:0] v, input logic [3:0] d,
                       input logic [3:0] ev, input logic [3:0] ed, input logic [3:0] edn,
                       input logic [3:0] edr, input logic eb);
        vec_t r;
        r.clr = clr; r.rt = rt; r.len = len; r.v = v; r.d = d;
        r.e_vld = ev; r.e_data = ed; r.e_done = edn; r.e_drop = edr; r.e_busy = eb;
        tbl.push_back(r);
    endtask

    initial begin
        int n, dn;
        bus.i_vld = '0;
        bus.i_data = '0;
        model_reset();

        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_vld",  32'(bus.o_vld),  0);
        chk("rst_data", 32'(bus.o_data), 0);
        chk("rst_done", 32'(bus.o_done), 0);
        chk("rst_drop", 32'(bus.o_drop), 0);
        chk("rst_busy", 32'(o_busy),     0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Expected values are the outputs in the cycle after each row's inputs are sampled.
        add(0,0,5,1,1, 1,1,0,0,1); add(0,0,5,0,0, 1,1,0,0,1); add(0,0,5,1,0, 1,1,0,1,1);
        add(0,0,5,0,0, 1,1,0,0,1); add(0,0,5,0,0, 1,1,0,0,1); add(0,0,5,0,0, 0,0,1,0,0);
        add(0,0,5,0,0, 0,0,0,0,0);
        add(0,1,5,1,0, 1,0,0,0,1); add(0,1,5,0,0, 1,0,0,0,1); add(0,1,5,1,1, 1,1,0,0,1);
        for (int k = 0; k < 4; k++) add(0,1,5,0,0, 1,1,0,0,1);
        add(0,1,5,0,0, 0,0,1,0,0); add(0,1,5,0,0, 0,0,0,0,0);
        add(0,0,3,1,1, 1,1,0,0,1); add(0,0,3,0,0, 1,1,0,0,1); add(0,0,3,0,0, 1,1,0,0,1);
        add(0,0,3,1,1, 1,1,1,0,1); add(0,0,3,0,0, 1,1,0,0,1); add(0,0,3,0,0, 1,1,0,0,1);
        add(0,0,3,0,0, 0,0,1,0,0); add(0,0,3,0,0, 0,0,0,0,0);
        add(0,0,3,1,1, 1,1,0,0,1); add(0,0,3,0,0, 1,1,0,0,1); add(1,0,3,1,1, 0,0,0,0,0);
        add(0,0,3,0,0, 0,0,0,0,0);
        add(0,0,0,1,1, 1,1,0,0,1); add(0,0,0,0,0, 0,0,1,0,0); add(0,0,0,0,0, 0,0,0,0,0);

        foreach (tbl[i]) begin
            cycle(tbl[i].clr, tbl[i].rt, tbl[i].len, tbl[i].v, tbl[i].d);
            chk($sformatf("t%0d_vld", i),  32'(bus.o_vld),  32'(tbl[i].e_vld));
            chk($sformatf("t%0d_data", i), 32'(bus.o_data), 32'(tbl[i].e_data));
            chk($sformatf("t%0d_done", i), 32'(bus.o_done), 32'(tbl[i].e_done));
            chk($sformatf("t%0d_drop", i), 32'(bus.o_drop), 32'(tbl[i].e_drop));
            chk($sformatf("t%0d_busy", i), 32'(o_busy),     32'(tbl[i].e_busy));
        end

        // Clamp to EXT_MAX, and a mid-window length change must not shorten the window.
        n = 0;
        cycle(0, 0, 31, 4'b0010, 4'b0010);
        for (int k = 0; k < 40; k++) begin
            if (bus.o_vld[1]) n++;
            cycle(0, 0, (k == 4) ? 5'd3 : 5'd31, 4'b0000, 4'b0000);
        end
        chk("clamp_len", n, EXT_MAX);

        // Asynchronous reset in the middle of windows on every channel.
        cycle(0, 0, 8, 4'hF, 4'hA);
        cycle(0, 0, 8, 4'h0, 4'h0);
        cycle(0, 0, 8, 4'h0, 4'h0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_vld",  32'(bus.o_vld),  0);
        chk("arst_data", 32'(bus.o_data), 0);
        chk("arst_done", 32'(bus.o_done), 0);
        chk("arst_drop", 32'(bus.o_drop), 0);
        chk("arst_busy", 32'(o_busy),     0);
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(0, 0, 8, 4'h0, 4'h0);
            if (bus.o_done != 0) dn++;
        end
        chk("arst_no_done", dn, 0);
        cycle(0, 0, 2, 4'b0100, 4'b0100);
        chk("post_rst_vld", 32'(bus.o_vld), 32'h4);
        for (int k = 0; k < 3; k++) cycle(0, 0, 2, 4'h0, 4'h0);

        // Randomised traffic against the model.
        for (int k = 0; k < 600; k++) begin
            logic [3:0] v;
            for (int c = 0; c < CH; c++) v[c] = ($urandom_range(0, 3) == 0);
            cycle($urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 20)), v, 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/signal_extend_mc.md
# signal_extend_mc

Multi-channel pulse stretcher with runtime-programmable stretch length and selectable retrigger mode. Each channel converts a single-cycle valid strobe, plus its data word, into a valid window of L consecutive cycles holding the captured data. A completion pulse marks the end of each window. The block sits between fault/event detectors and slow-sampling consumers such as register-file status capture and cross-domain handshakes, where event pulses must be held long enough to be seen.

## Interface
- CH_NUM, 4, number of independent channels
- DATA_W, 1, data width per channel
- EXT_MAX, 16, maximum window length in cycles (≥1)
- CNT_W, derived = $clog2(EXT_MAX+1), counter and length width (localparam)

- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_clr  in  1  synchronous clear of all channels
- i_retrig  in  1  mode: 1 = retrigger extends window, 0 = ignore triggers while active
- i_ext_len  in  CNT_W  requested window length, shared by all channels
- i_vld  in  CH_NUM  per-channel trigger strobe
- i_data  in  CH_NUM*DATA_W  per-channel data; channel c uses bits [c*DATA_W +: DATA_W]
- o_vld  out  CH_NUM  per-channel window active
- o_data  out  CH_NUM*DATA_W  captured data while o_vld is high, 0 otherwise
- o_done  out  CH_NUM  one-cycle pulse after a window completes
- o_drop  out  CH_NUM  one-cycle pulse when a trigger is ignored
- o_busy  out  1  OR of all o_vld bits (registered)

## Operation
- Effective length L = 1 if i_ext_len == 0; EXT_MAX if i_ext_len > EXT_MAX; otherwise i_ext_len.
- L is sampled at trigger time into the per-channel len_lat register. Later changes to i_ext_len do not affect a running window.
- Each channel has state registers: o_vld (active flag), cnt[CNT_W], len_lat[CNT_W] and data_lat[DATA_W]. Channels are fully independent.
- A trigger is accepted when i_vld[c] is high and any one of the following holds:
  - the channel is idle;
  - the channel is in its final cycle (cnt == len_lat);
  - i_retrig == 1.
- On an accepted trigger at the next edge: o_vld <= 1, cnt <= 1, len_lat <= L, data_lat <= i_data slice.
- Active with no accepted trigger:
  - if cnt == len_lat: o_vld <= 0 and data_lat <= 0 (window complete);
  - otherwise cnt <= cnt + 1.
- Non-accepted trigger: occurs only when i_retrig == 0, the channel is active and cnt != len_lat. State is unchanged and o_drop[c] pulses for one cycle at the next edge.
- o_done[c] is registered: it equals the previous cycle's (o_vld & cnt == len_lat). It therefore pulses for every window that runs to completion, including a window followed back-to-back by a new one.
- A retrigger-aborted window (reload while cnt < len_lat) produces no o_done.
- o_data = data_lat (held at 0 when idle).
- i_clr has priority over i_vld. At the next edge it forces all state to reset values; o_done and o_drop are 0.
- o_busy <= |(next o_vld).

## Timing
- Reset values: o_vld=0, o_data=0, o_done=0, o_drop=0, o_busy=0, cnt=0, len_lat=0.
- Latency is 1 cycle: i_vld sampled at edge N gives o_vld high from cycle N+1 through cycle N+L.
- o_done is high in cycle N+L+1.
- Back-to-back trigger sampled in the final cycle: o_vld stays continuously high, with no gap cycle.
- Simultaneous i_vld on several channels: each channel is handled independently in the same cycle.
- Asynchronous reset mid-window: all outputs go to 0 immediately; no o_done is issued afterwards.
- Counter never exceeds len_lat ≤ EXT_MAX, so there is no wrap-around.

## Test plan
- L=1: i_ext_len=0, pulse i_vld[0] with i_data=1 -> o_vld[0] high exactly 1 cycle with o_data[0]=1; o_done[0] pulses the following cycle.
- Clamp: EXT_MAX=16, i_ext_len=31, pulse i_vld[1] -> o_vld[1] high 16 cycles; changing i_ext_len to 3 mid-window has no effect.
- No-retrigger: i_retrig=0, L=5, triggers at cycles 0 and 2 -> window covers cycles 1–5; o_drop pulses in cycle 3; one o_done in cycle 6.
- Retrigger: i_retrig=1, L=5, triggers at cycles 0 and 2 (data 0 then 1) -> o_vld high cycles 1–7; o_data switches to 1 at cycle 3; single o_done at cycle 8.
- Back-to-back and clear: L=3, triggers at 0 and 3 -> o_vld high cycles 1–6 continuously; o_done at 4 and 7. Separately, i_clr at cycle 2 -> o_vld/o_busy low from cycle 3 with no o_done.
- Async reset asserted mid-window on all 4 channels -> every output is 0 immediately; after release, a fresh trigger behaves normally.
